// File: rtl/dmem_responder.sv
// dmem_responder: single-port word memory behind a req/ack handshake.
// A request is captured in IDLE and completed a fixed LATENCY cycles later
// with a one-cycle o_ack pulse. Stores honour per-byte lane enables.
//
// Handshake: i_req is a level held by the initiator until it sees o_ack.
// The block samples i_req only in IDLE. Address, data and lane enables are
// taken at that capture edge. Inputs other than i_rst are ignored until the
// FSM is back in IDLE, so a request held across ACK starts the next
// transaction on the edge after ACK.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_data_wr,
  input  logic [3:0]            i_we,
  output logic                  o_ack,
  output logic                  o_err,
  output logic [31:0]           o_data_rd,
  output logic                  o_busy,
  output logic [1:0]            o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
  localparam bit         DIRECT   = (LATENCY == 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic [3:0]            we_q;

  logic                  commit;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [31:0]           c_data;
  logic [3:0]            c_we;
  logic                  c_legal;

  logic [31:0]           mem [2**ADDR_WIDTH];

  // Only single bytes, aligned halfwords, the full word, or a read are legal.
  function automatic logic lane_legal(input logic [3:0] we);
    case (we)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: lane_legal = 1'b1;
      default:                   lane_legal = 1'b0;
    endcase
  endfunction

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; commit marks the edge that enters ACK.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req) begin
          state_d = DIRECT ? ACK : WAIT;
          commit  = DIRECT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = ACK;
          commit  = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With LATENCY=1 the commit edge is also the capture edge, so the live
  // inputs are used; otherwise the captured copies are.
  always_comb begin
    c_addr  = (state_q == IDLE) ? i_addr    : addr_q;
    c_data  = (state_q == IDLE) ? i_data_wr : data_q;
    c_we    = (state_q == IDLE) ? i_we      : we_q;
    c_legal = lane_legal(c_we);
  end

  // Request capture and latency down-counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q  <= 4'd0;
      addr_q <= '0;
      data_q <= 32'h0;
      we_q   <= 4'h0;
    end else if (state_q == IDLE && i_req) begin
      cnt_q  <= CNT_LOAD;
      addr_q <= i_addr;
      data_q <= i_data_wr;
      we_q   <= i_we;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Read data register; only completed reads update it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                       o_data_rd <= 32'h0;
    else if (commit && c_we == 4'h0) o_data_rd <= mem[c_addr];
  end

  // Memory array: never cleared, lane-masked writes on the commit edge.
  always_ff @(posedge i_clk) begin
    if (commit && c_legal && !i_rst) begin
      for (int i = 0; i < 4; i++) begin
        if (c_we[i]) mem[c_addr][8*i +: 8] <= c_data[8*i +: 8];
      end
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    o_ack   = (state_q == ACK);
    o_err   = (state_q == ACK) && !lane_legal(we_q);
    o_busy  = (state_q != IDLE);
    o_state = state_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic
// checked against a word-array model of the memory.
module tb_dmem_responder;

  localparam int AW = 4;

  logic          clk;
  logic          rst;
  logic          req, req1;
  logic [AW-1:0] addr, addr1;
  logic [31:0]   wdata, wdata1;
  logic [3:0]    we, we1;
  logic          ack, ack1, err, err1, busy, busy1;
  logic [31:0]   rdata, rdata1;
  logic [1:0]    state, state1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q [$];
  logic [31:0] model_mem [2**AW];
  logic [31:0] model_rd;

  dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(2)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_addr(addr), .i_data_wr(wdata),
    .i_we(we), .o_ack(ack), .o_err(err), .o_data_rd(rdata), .o_busy(busy),
    .o_state(state)
  );

  dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_req(req1), .i_addr(addr1), .i_data_wr(wdata1),
    .i_we(we1), .o_ack(ack1), .o_err(err1), .o_data_rd(rdata1), .o_busy(busy1),
    .o_state(state1)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit model_legal(input logic [3:0] w);
    logic [3:0] ok [8];
    ok = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    model_legal = 1'b0;
    foreach (ok[i]) if (ok[i] == w) model_legal = 1'b1;
  endfunction

  // Applies a transaction to the model; returns expected err and read data.
  task automatic model_apply(input logic [AW-1:0] a, input logic [3:0] w,
                             input logic [31:0] d, output logic e_err,
                             output logic [31:0] e_rd);
    logic [7:0] bytes [4];
    e_err = !model_legal(w);
    if (!e_err && w == 4'h0) begin
      model_rd = model_mem[a];
    end else if (!e_err) begin
      for (int i = 0; i < 4; i++) bytes[i] = model_mem[a][8*i +: 8];
      for (int i = 0; i < 4; i++) if (w[i]) bytes[i] = d[8*i +: 8];
      model_mem[a] = {bytes[3], bytes[2], bytes[1], bytes[0]};
    end
    e_rd = model_rd;
  endtask

  // ---------------- driver ----------------
  // One transaction on the LATENCY=2 instance. lat is the number of falling
  // edges from capture to the first one seeing o_ack (99 on timeout).
  // proto_bad counts busy low mid-transaction, err without ack, or a
  // non-idle cycle right after ack.
  task automatic drive_txn(input logic [AW-1:0] a, input logic [3:0] w,
                           input logic [31:0] d, input bit scramble,
                           output int lat, output logic [31:0] rd,
                           output logic er, output int proto_bad);
    lat = 99; proto_bad = 0; rd = 'x; er = 'x;
    @(negedge clk);
    req = 1'b1; addr = a; we = w; wdata = d;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (scramble) begin
        addr = AW'($urandom); we = 4'($urandom); wdata = $urandom;
      end
      if (!busy) proto_bad++;
      if (ack) begin
        lat = c; rd = rdata; er = err;
        break;
      end
      if (err) proto_bad++;
    end
    req = 1'b0;
    @(negedge clk);
    if (ack || busy || err) proto_bad++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; req = 0; req1 = 0; addr = 0; addr1 = 0;
    wdata = 0; wdata1 = 0; we = 0; we1 = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ack, err, busy, rdata} !== 35'h0) $display("FAIL reset_l2: got ack=%b err=%b busy=%b rd=%h want all 0", ack, err, busy, rdata);
    else n_pass++;
    n_checks++;
    if ({ack1, err1, busy1, rdata1} !== 35'h0) $display("FAIL reset_l1: got ack=%b err=%b busy=%b rd=%h want all 0", ack1, err1, busy1, rdata1);
    else n_pass++;
    rst = 1'b0;
    model_rd = 32'h0;
  endtask

  task automatic test_fill();
    int lat, pb; logic [31:0] rd, erd; logic er, eer;
    for (int i = 0; i < 2**AW; i++) begin
      logic [31:0] d;
      d = (i == 3) ? 32'h0 : $urandom;
      model_apply(AW'(i), 4'hF, d, eer, erd);
      drive_txn(AW'(i), 4'hF, d, 1'b0, lat, rd, er, pb);
      n_checks++;
      if (lat !== 2 || pb !== 0 || er !== eer || rd !== erd)
        $display("FAIL fill[%0d]: got lat=%0d proto=%0d err=%b rd=%h want lat=2 proto=0 err=%b rd=%h", i, lat, pb, er, rd, eer, erd);
      else n_pass++;
    end
  endtask

  task automatic test_directed();
    logic [AW-1:0] a [7];
    logic [3:0]    w [7];
    logic [31:0]   d [7];
    int lat, pb; logic [31:0] rd, erd; logic er, eer;
    a = '{4'd5, 4'd5, 4'd7, 4'd7, 4'd7, 4'd7, 4'd7};
    w = '{4'hF, 4'h0, 4'hF, 4'h8, 4'h0, 4'hC, 4'h0};
    d = '{32'hDEADBEEF, 32'h0, 32'h11223344, 32'hAA000000, 32'h0, 32'h55660000, 32'h0};
    for (int i = 0; i < 7; i++) begin
      model_apply(a[i], w[i], d[i], eer, erd);
      exp_q.push_back(erd);
      drive_txn(a[i], w[i], d[i], 1'b0, lat, rd, er, pb);
      n_checks++;
      if (lat !== 2 || pb !== 0 || er !== eer || rd !== exp_q.pop_front())
        $display("FAIL directed[%0d]: got lat=%0d proto=%0d err=%b rd=%h want lat=2 proto=0 err=%b rd=%h", i, lat, pb, er, rd, eer, erd);
      else n_pass++;
    end
    // Absolute values stated for this sequence.
    n_checks++;
    if (model_mem[5] !== 32'hDEADBEEF || model_mem[7] !== 32'h55663344)
      $display("FAIL directed_model: got m5=%h m7=%h want deadbeef 55663344", model_mem[5], model_mem[7]);
    else n_pass++;
    // Illegal 0101 lanes: err with ack, no write, read data unchanged.
    drive_txn(4'd7, 4'b0101, 32'hFFFFFFFF, 1'b0, lat, rd, er, pb);
    n_checks++;
    if (lat !== 2 || pb !== 0 || er !== 1'b1 || rd !== 32'h55663344)
      $display("FAIL illegal_lanes: got lat=%0d proto=%0d err=%b rd=%h want lat=2 proto=0 err=1 rd=55663344", lat, pb, er, rd);
    else n_pass++;
    drive_txn(4'd7, 4'h0, 32'h0, 1'b0, lat, rd, er, pb);
    n_checks++;
    if (er !== 1'b0 || rd !== 32'h55663344)
      $display("FAIL illegal_no_write: got err=%b rd=%h want err=0 rd=55663344", er, rd);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int lat, pb, acks; logic [31:0] rd; logic er;
    acks = 0;
    @(negedge clk);
    req = 1'b1; addr = 4'd3; we = 4'hF; wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || ack !== 1'b0) $display("FAIL abort_in_wait: got busy=%b ack=%b want busy=1 ack=0", busy, ack);
    else n_pass++;
    #1 rst = 1'b1; req = 1'b0;
    #1;
    n_checks++;
    if ({ack, err, busy, rdata} !== 35'h0) $display("FAIL abort_outputs: got ack=%b err=%b busy=%b rd=%h want all 0", ack, err, busy, rdata);
    else n_pass++;
    model_rd = 32'h0;
    @(negedge clk); if (ack) acks++;
    rst = 1'b0;
    repeat (3) begin @(negedge clk); if (ack) acks++; end
    n_checks++;
    if (acks !== 0) $display("FAIL abort_no_ack: got %0d acks want 0", acks);
    else n_pass++;
    drive_txn(4'd3, 4'h0, 32'h0, 1'b0, lat, rd, er, pb);
    n_checks++;
    if (lat !== 2 || rd !== 32'h00000000 || er !== 1'b0)
      $display("FAIL abort_no_write: got lat=%0d rd=%h err=%b want lat=2 rd=00000000 err=0", lat, rd, er);
    else n_pass++;
  endtask

  // Random traffic; odd iterations scramble inputs while the DUT is busy.
  task automatic test_random();
    int lat, pb; logic [31:0] rd, erd; logic er, eer;
    for (int i = 0; i < 150; i++) begin
      logic [AW-1:0] a; logic [3:0] w; logic [31:0] d;
      a = AW'($urandom_range(0, 2**AW - 1));
      w = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      d = $urandom;
      model_apply(a, w, d, eer, erd);
      drive_txn(a, w, d, bit'(i % 2), lat, rd, er, pb);
      n_checks++;
      if (lat !== 2 || pb !== 0 || er !== eer || rd !== erd)
        $display("FAIL random[%0d] a=%h we=%b: got lat=%0d proto=%0d err=%b rd=%h want lat=2 proto=0 err=%b rd=%h", i, a, w, lat, pb, er, rd, eer, erd);
      else n_pass++;
    end
  endtask

  // LATENCY=1 instance with i_req held: ack every other cycle, busy equal to
  // ack. Two writes then reads of the same word.
  task automatic test_back_to_back();
    logic [31:0] d;
    d = $urandom;
    @(negedge clk);
    req1 = 1'b1; addr1 = 4'd2; we1 = 4'hF; wdata1 = d;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (ack1 !== (k % 2 == 0) || busy1 !== (k % 2 == 0) || err1 !== 1'b0)
        $display("FAIL b2b[%0d]: got ack=%b busy=%b err=%b want ack=%0d busy=%0d err=0", k, ack1, busy1, err1, k % 2 == 0, k % 2 == 0);
      else n_pass++;
      if (k >= 4 && k % 2 == 0) begin
        n_checks++;
        if (rdata1 !== d) $display("FAIL b2b_read[%0d]: got %h want %h", k, rdata1, d);
        else n_pass++;
      end
      if (k == 2) begin we1 = 4'h0; wdata1 = ~d; end
    end
    req1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_directed();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
